// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential radix-2 Booth multiplier.
// Holds the FSM state encoding and the Booth recoding helper.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_1}.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mult_booth_step.sv
// One combinational Booth iteration: conditional add/subtract of M into acc,
// then arithmetic shift right of {acc, Q, q_1} by one bit.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic [WIDTH:0]   acc_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_1_in,
  input  logic [WIDTH:0]   m_in,
  output logic [WIDTH:0]   acc_out,
  output logic [WIDTH-1:0] q_out,
  output logic             q_1_out
);

  booth_op_t      op;
  logic [WIDTH:0] sum;

  always_comb begin
    op = booth_decode(q_in[0], q_1_in);
    sum = acc_in;
    case (op)
      OP_ADD:  sum = acc_in + m_in;
      OP_SUB:  sum = acc_in - m_in;
      default: sum = acc_in;
    endcase
    // Sign bit of the (WIDTH+1)-bit accumulator is replicated on the shift.
    acc_out = {sum[WIDTH], sum[WIDTH:1]};
    q_out   = {sum[0], q_in[WIDTH-1:1]};
    q_1_out = q_in[0];
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed WIDTH x WIDTH multiplier, one Booth step per clock.
// Accepts in IDLE on control, publishes the product on Hi/Lo with a done pulse.
module mult_booth
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH:0]   acc_reg, acc_next;
  logic [WIDTH:0]   m_reg, m_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             q_1_reg, q_1_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_q_1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_in (acc_reg),
    .q_in   (q_reg),
    .q_1_in (q_1_reg),
    .m_in   (m_reg),
    .acc_out(step_acc),
    .q_out  (step_q),
    .q_1_out(step_q_1)
  );

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    q_1_next   = q_1_reg;
    count_next = count_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (control) begin
          m_next     = {A[WIDTH-1], A};
          acc_next   = '0;
          q_next     = B;
          q_1_next   = 1'b0;
          count_next = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next   = step_acc;
        q_next     = step_q;
        q_1_next   = step_q_1;
        count_next = count_reg + CNT_W'(1);
        if (count_reg == CNT_W'(WIDTH - 1)) state_next = DONE;
      end
      DONE: begin
        // acc[WIDTH] is only guard headroom; the product is {acc[WIDTH-1:0], Q}.
        hi_next    = acc_reg[WIDTH-1:0];
        lo_next    = q_reg;
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      m_reg     <= '0;
      q_reg     <= '0;
      q_1_reg   <= 1'b0;
      count_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      q_1_reg   <= q_1_next;
      count_reg <= count_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      done_reg  <= done_next;
    end
  end

  assign Hi   = hi_reg;
  assign Lo   = lo_reg;
  assign done = done_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mult_booth.sv
// Directed self-checking bench for mult_booth: one task per scenario,
// hand-computed products, latency and handshake checks.
module tb_mult_booth;

  logic        clk;
  logic        reset;
  logic        control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        busy;
  logic        done;

  int errors;
  int checks;

  mult_booth dut (
    .clk    (clk),
    .reset  (reset),
    .control(control),
    .A      (A),
    .B      (B),
    .Hi     (Hi),
    .Lo     (Lo),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse control for one edge with operands a/b, then wait for done.
  // lat = negedges after the accept edge until done is seen; busy_cnt = busy samples.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output bit got);
    @(negedge clk);
    A = a; B = b; control = 1'b1;
    @(negedge clk);
    control = 1'b0;
    lat = 0; busy_cnt = 0; got = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    got = done;
  endtask

  task automatic test_reset;
    reset = 1'b0; control = 1'b0; A = '0; B = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({Hi, Lo, busy, done} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: Hi=%h Lo=%h busy=%b done=%b required all zero", Hi, Lo, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
    $display("reset: Hi=%h Lo=%h busy=%b done=%b", Hi, Lo, busy, done);
  endtask

  task automatic test_basic;
    int lat, bc; bit got;
    run_op(32'd3, 32'd4, lat, bc, got);
    checks++;
    if (!got || lat !== 33) begin
      errors++;
      $display("FAIL basic_latency: got done=%b after %0d cycles, required 33", got, lat);
    end
    checks++;
    if ({Hi, Lo} !== 64'h0000_0000_0000_000C) begin
      errors++;
      $display("FAIL basic_3x4: Hi=%h Lo=%h required 00000000 0000000c", Hi, Lo);
    end
    checks++;
    if (bc !== 33) begin
      errors++;
      $display("FAIL basic_busy: busy cycles %0d required 33", bc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b busy=%b one cycle later, required 0 0", done, busy);
    end
    $display("basic 3*4: Hi=%h Lo=%h latency=%0d", Hi, Lo, lat);
  endtask

  task automatic test_signed;
    int lat, bc; bit got;
    run_op(32'hFFFF_FFFD, 32'd4, lat, bc, got);
    checks++;
    if (!got || {Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFF4) begin
      errors++;
      $display("FAIL signed_m3x4: done=%b Hi=%h Lo=%h required ffffffff fffffff4", got, Hi, Lo);
    end
    $display("signed -3*4: Hi=%h Lo=%h", Hi, Lo);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, got);
    checks++;
    if (!got || {Hi, Lo} !== 64'h0000_0000_0000_0001) begin
      errors++;
      $display("FAIL signed_m1xm1: done=%b Hi=%h Lo=%h required 00000000 00000001", got, Hi, Lo);
    end
    $display("signed -1*-1: Hi=%h Lo=%h", Hi, Lo);
  endtask

  task automatic test_boundary;
    int lat, bc; bit got;
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [63:0] vp [3];
    va[0] = 32'h8000_0000; vb[0] = 32'h8000_0000; vp[0] = 64'h4000_0000_0000_0000;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h7FFF_FFFF; vp[1] = 64'h3FFF_FFFF_0000_0001;
    va[2] = 32'h8000_0000; vb[2] = 32'h7FFF_FFFF; vp[2] = 64'hC000_0000_8000_0000;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], lat, bc, got);
      checks++;
      if (!got || {Hi, Lo} !== vp[i]) begin
        errors++;
        $display("FAIL boundary_%0d: done=%b Hi=%h Lo=%h required %h", i, got, Hi, Lo, vp[i]);
      end
      $display("boundary %h*%h: Hi=%h Lo=%h", va[i], vb[i], Hi, Lo);
    end
  endtask

  task automatic test_operand_change;
    int lat; bit seen_busy;
    @(negedge clk);
    A = 32'd5; B = 32'd6; control = 1'b1;
    @(negedge clk);
    control = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'hDEAD_BEEF; B = 32'hDEAD_BEEF; control = 1'b1;
    @(negedge clk);
    control = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done || {Hi, Lo} !== 64'd30) begin
      errors++;
      $display("FAIL operand_change: done=%b Hi=%h Lo=%h required 00000000 0000001e", done, Hi, Lo);
    end
    seen_busy = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) seen_busy = 1;
    end
    checks++;
    if (seen_busy !== 1'b0) begin
      errors++;
      $display("FAIL no_second_op: busy seen=%b after done, required 0", seen_busy);
    end
    $display("operand change 5*6: Hi=%h Lo=%h", Hi, Lo);
  endtask

  task automatic test_back_to_back;
    int lat, gap;
    @(negedge clk);
    A = 32'd7; B = 32'd8; control = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!done || {Hi, Lo} !== 64'd56) begin
      errors++;
      $display("FAIL b2b_first: done=%b Hi=%h Lo=%h required 00000000 00000038", done, Hi, Lo);
    end
    $display("b2b first 7*8: Hi=%h Lo=%h", Hi, Lo);
    A = 32'd9; B = 32'd10;
    gap = 0;
    @(negedge clk);
    gap++;
    control = 1'b0;
    while (!done && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (!done || gap !== 34) begin
      errors++;
      $display("FAIL b2b_gap: done=%b gap %0d cycles, required 34", done, gap);
    end
    checks++;
    if ({Hi, Lo} !== 64'd90) begin
      errors++;
      $display("FAIL b2b_second: Hi=%h Lo=%h required 00000000 0000005a", Hi, Lo);
    end
    $display("b2b second 9*10: Hi=%h Lo=%h gap=%0d", Hi, Lo, gap);
  endtask

  task automatic test_reset_abort;
    int lat, bc; bit got; bit seen_done;
    @(negedge clk);
    A = 32'd11; B = 32'd13; control = 1'b1;
    @(negedge clk);
    control = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checks++;
    if ({Hi, Lo} !== 64'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_state: Hi=%h Lo=%h busy=%b required 0 0 0", Hi, Lo, busy);
    end
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done seen=%b after abort, required 0", seen_done);
    end
    run_op(32'd2, 32'd3, lat, bc, got);
    checks++;
    if (!got || {Hi, Lo} !== 64'd6) begin
      errors++;
      $display("FAIL abort_recover: done=%b Hi=%h Lo=%h required 00000000 00000006", got, Hi, Lo);
    end
    $display("reset abort then 2*3: Hi=%h Lo=%h", Hi, Lo);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_basic;
    test_signed;
    test_boundary;
    test_operand_change;
    test_back_to_back;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_booth.md
Name: mult_booth

Overview:
- Sequential signed 32x32 -> 64-bit multiplier for the CPU datapath. Implements the MULT instruction.
- Complement of the existing iterative divider. Drives the same Hi/Lo register pair using the MIPS convention: Hi = product[63:32], Lo = product[31:0].
- Radix-2 Booth recoding, one iteration per clock, single start/done handshake to the control unit.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low; sampled on the rising edge of clk; 0 = reset.
- control  input  1  start request from the control unit; level-sampled only in IDLE.
- A  input  WIDTH  multiplicand, signed two's complement.
- B  input  WIDTH  multiplier, signed two's complement.
- Hi  output  WIDTH  upper half of the product, registered.
- Lo  output  WIDTH  lower half of the product, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; Hi/Lo valid from that cycle.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; Hi=0, Lo=0, done=0, busy=0; internal acc/Q/q_1/M/count cleared. Reset has priority over everything. Reset mid-operation aborts; no done is produced.
- Internal registers:
  - M: WIDTH+1 bits, sign-extended A.
  - acc: WIDTH+1 bits.
  - Q: WIDTH bits.
  - q_1: 1 bit.
  - count: CNT_W bits.
- States: IDLE, RUN, DONE.
- IDLE, control==1 at edge k (accept):
  - M <= sext(A); acc <= 0; Q <= B; q_1 <= 0; count <= 0; go to RUN.
  - A and B are sampled only at this edge; later changes are ignored.
- IDLE, control==0: hold; Hi/Lo keep their last values.
- RUN, every edge, one Booth step:
  - {Q[0],q_1}==10: acc' = acc - M.
  - {Q[0],q_1}==01: acc' = acc + M.
  - 00 or 11: acc' = acc.
  - Then arithmetic shift right of {acc',Q,q_1} by 1; the MSB of acc' is replicated.
  - count <= count+1.
  - When the step taking count from WIDTH-1 to WIDTH completes (edge k+WIDTH), go to DONE.
- Width rule: acc is WIDTH+1 bits so that A = -2^(WIDTH-1) does not overflow. The final product = {acc[WIDTH-1:0], Q}.
- DONE, edge k+WIDTH+1: Hi <= acc[WIDTH-1:0]; Lo <= Q; done <= 1 for exactly this one cycle; go to IDLE.
- Latency: accept at edge k; Hi/Lo/done updated at edge k+33 (WIDTH=32); done deasserts at edge k+34.
- control is ignored while busy. No queuing.
- control held high continuously: re-accepts at the edge after DONE, giving back-to-back operations every 34 cycles.
- done and an accept never occur in the same cycle, because accept happens only in IDLE.
- Hi/Lo change only at the DONE edge or on reset. There are no intermediate values on Hi/Lo.
- No zero/overflow flags; the full 64-bit product is always exact.

Decomposition:
- Package mult_pkg:
  - WIDTH default.
  - State enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Booth op encoding {NOP, ADD, SUB}.
- Sub-module booth_step (combinational):
  - Inputs: acc, Q, q_1, M.
  - Outputs: next acc, Q, q_1.
  - Performs add/sub plus arithmetic shift.
  - Top level holds the FSM, counter and output registers.
  - Lets verification check a single step exhaustively on small WIDTH.

Test Plan:
- A=3, B=4, control pulsed 1 cycle -> done 33 edges after accept; Hi=0x00000000, Lo=0x0000000C; busy high for 33 cycles.
- A=0xFFFFFFFD (-3), B=4 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF4; also A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0, Lo=1.
- Boundaries:
  - A=B=0x80000000 -> Hi=0x40000000, Lo=0.
  - A=B=0x7FFFFFFF -> Hi=0x3FFFFFFF, Lo=0x00000001.
  - A=0x80000000, B=0x7FFFFFFF -> Hi=0xC0000000, Lo=0x80000000.
- Accept A=5, B=6, then change A/B to 0xDEADBEEF and pulse control during RUN -> result still Hi=0, Lo=30; no second operation starts.
- control held high across two operations (7*8, then operands switched to 9*10 right after the first done) -> done pulses 34 cycles apart; Lo=56, then Lo=90.
- Drive reset=0 at edge 10 of a run -> Hi=Lo=0, busy=0, no done; the next operation 2*3 completes normally with Lo=6.
